// File: rtl/tx_ila_gen_if.sv
// JESD204B ILA generator port bundle: enable/config in, octet stream out.
// Latency: none (wires only).
// Backpressure: none; the octet stream is free-running once enabled.
interface tx_ila_gen_if;
    logic         i_ila_en;
    logic [111:0] i_cfg;
    logic [7:0]   o_data;
    logic         o_is_k;
    logic         o_valid;
    logic         o_ila_end;
    logic         o_busy;

    // Generator side
    modport master (
        input  i_ila_en,
        input  i_cfg,
        output o_data,
        output o_is_k,
        output o_valid,
        output o_ila_end,
        output o_busy
    );

    // Consumer side (tx_control / octet mux)
    modport slave (
        output i_ila_en,
        output i_cfg,
        input  o_data,
        input  o_is_k,
        input  o_valid,
        input  o_ila_end,
        input  o_busy
    );
endinterface

// File: rtl/tx_ila_gen.sv
// JESD204B Initial Lane Alignment octet stream generator for one lane (MF_NUM multiframes).
// Latency: first /R/ one cycle after the edge that samples i_ila_en=1; one octet per cycle.
// Backpressure: none; dropping i_ila_en mid-sequence aborts to idle on the next edge.
module tx_ila_gen #(
    parameter int F      = 2,
    parameter int K      = 16,
    parameter int MF_NUM = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    tx_ila_gen_if.master ila
);

    localparam int FK = F * K;
    localparam int CW = $clog2(FK);
    localparam int MW = $clog2(MF_NUM);

    localparam logic [CW-1:0] POS_LAST = CW'(FK - 1);
    localparam logic [MW-1:0] MF_LAST  = MW'(MF_NUM - 1);

    localparam logic [7:0] K28_0_R = 8'h1C;
    localparam logic [7:0] K28_3_A = 8'h7C;
    localparam logic [7:0] K28_4_Q = 8'h9C;

    // Reject configurations that cannot hold /R/, /Q/, 14 config octets and /A/ in one multiframe.
    generate
        if (F < 1 || F > 256) begin : g_bad_f
            $error("tx_ila_gen: F must be in 1..256");
        end
        if (FK < 17 || FK > 1024) begin : g_bad_fk
            $error("tx_ila_gen: F*K must be in 17..1024");
        end
        if (MF_NUM < 2) begin : g_bad_mf
            $error("tx_ila_gen: MF_NUM must be >= 2");
        end
    endgenerate

    typedef enum logic [2:0] {
        S_IDLE = 3'b001,
        S_RUN  = 3'b010,
        S_DONE = 3'b100
    } state_t;

    state_t        state;
    logic [CW-1:0] oct_cnt;
    logic [MW-1:0] mf_cnt;
    logic [111:0]  cfg_q;

    logic          last_oct;
    logic          last_mf;
    logic [3:0]    cfg_sel;
    logic [127:0]  cfg_ext;
    logic [7:0]    nxt_data;
    logic          nxt_is_k;

    assign last_oct = (oct_cnt == POS_LAST);
    assign last_mf  = (mf_cnt == MF_LAST);
    assign cfg_sel  = 4'(oct_cnt - CW'(2));
    assign cfg_ext  = {16'h0000, cfg_q};

    // Pick the octet for the current (mf_cnt, oct_cnt) position; registered below.
    always_comb begin
        nxt_data = 8'(oct_cnt);
        nxt_is_k = 1'b0;
        if (oct_cnt == '0) begin
            nxt_data = K28_0_R;
            nxt_is_k = 1'b1;
        end else if (last_oct) begin
            nxt_data = K28_3_A;
            nxt_is_k = 1'b1;
        end else if (mf_cnt == MW'(1) && oct_cnt == CW'(1)) begin
            nxt_data = K28_4_Q;
            nxt_is_k = 1'b1;
        end else if (mf_cnt == MW'(1) && oct_cnt >= CW'(2) && oct_cnt <= CW'(15)) begin
            nxt_data = cfg_ext[{cfg_sel, 3'b000} +: 8];
        end
    end

    // Sequencer: counters, state and registered octet outputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= S_IDLE;
            oct_cnt       <= '0;
            mf_cnt        <= '0;
            cfg_q         <= '0;
            ila.o_data    <= 8'h00;
            ila.o_is_k    <= 1'b0;
            ila.o_valid   <= 1'b0;
            ila.o_ila_end <= 1'b0;
            ila.o_busy    <= 1'b0;
        end else begin
            // Outputs idle unless RUN overrides them below.
            ila.o_data    <= 8'h00;
            ila.o_is_k    <= 1'b0;
            ila.o_valid   <= 1'b0;
            ila.o_ila_end <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    oct_cnt <= '0;
                    mf_cnt  <= '0;
                    if (ila.i_ila_en) begin
                        state      <= S_RUN;
                        cfg_q      <= ila.i_cfg;
                        ila.o_busy <= 1'b1;
                    end
                end
                S_RUN: begin
                    if (!ila.i_ila_en) begin
                        // Abort: back to idle, nothing emitted this edge.
                        state      <= S_IDLE;
                        oct_cnt    <= '0;
                        mf_cnt     <= '0;
                        ila.o_busy <= 1'b0;
                    end else begin
                        ila.o_data    <= nxt_data;
                        ila.o_is_k    <= nxt_is_k;
                        ila.o_valid   <= 1'b1;
                        ila.o_ila_end <= last_oct && last_mf;
                        if (last_oct) begin
                            oct_cnt <= '0;
                            if (last_mf) begin
                                mf_cnt     <= '0;
                                state      <= S_DONE;
                                ila.o_busy <= 1'b0;
                            end else begin
                                mf_cnt <= mf_cnt + 1'b1;
                            end
                        end else begin
                            oct_cnt <= oct_cnt + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    // Wait for the enable to drop before a new sequence may start.
                    if (!ila.i_ila_en) begin
                        state <= S_IDLE;
                    end
                end
                default: begin
                    state      <= S_IDLE;
                    oct_cnt    <= '0;
                    mf_cnt     <= '0;
                    ila.o_busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_tx_ila_gen.sv
// Bench for tx_ila_gen: scoreboard of expected ILA octets plus spot-check vector table.
// Latency: n/a.
// Backpressure: n/a.
module tb_tx_ila_gen;

    typedef struct packed {
        logic       e;
        logic       k;
        logic [7:0] d;
    } exp_t;

    typedef struct {
        int   dut;
        int   idx;
        exp_t val;
    } vec_t;

    logic clk;
    logic rst_n;

    tx_ila_gen_if a_if ();
    tx_ila_gen_if b_if ();

    tx_ila_gen #(.F(2), .K(16), .MF_NUM(4)) dut_a (
        .clk   (clk),
        .rst_n (rst_n),
        .ila   (a_if)
    );

    tx_ila_gen #(.F(1), .K(17), .MF_NUM(4)) dut_b (
        .clk   (clk),
        .rst_n (rst_n),
        .ila   (b_if)
    );

    int   checks = 0;
    int   errors = 0;
    exp_t qa[$];
    exp_t qb[$];
    exp_t cap_a [0:127];
    exp_t cap_b [0:67];
    int   cap_a_n = 0;
    int   cap_b_n = 0;
    vec_t vt[$];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", nm, act, req);
        end
    endtask

    // Reference model of one ILA octet.
    function automatic exp_t model(input int f, input int k, input int m, input int pos,
                                   input logic [111:0] cfg);
        exp_t        x;
        int          fk;
        logic [31:0] p;
        fk  = f * k;
        p   = pos;
        x.e = 1'b0;
        x.k = 1'b0;
        x.d = p[7:0];
        if (pos == 0) begin
            x.d = 8'h1C; x.k = 1'b1;
        end else if (pos == fk - 1) begin
            x.d = 8'h7C; x.k = 1'b1; x.e = (m == 3);
        end else if (m == 1 && pos == 1) begin
            x.d = 8'h9C; x.k = 1'b1;
        end else if (m == 1 && pos >= 2 && pos <= 15) begin
            x.d = cfg[(pos - 2) * 8 +: 8];
        end
        return x;
    endfunction

    task automatic push_seq(input int which, input int f, input int k, input logic [111:0] cfg);
        for (int m = 0; m < 4; m++) begin
            for (int pos = 0; pos < f * k; pos++) begin
                if (which != 0) qb.push_back(model(f, k, m, pos, cfg));
                else            qa.push_back(model(f, k, m, pos, cfg));
            end
        end
    endtask

    function automatic logic vld(input int w);
        return (w != 0) ? b_if.o_valid : a_if.o_valid;
    endfunction
    function automatic logic endp(input int w);
        return (w != 0) ? b_if.o_ila_end : a_if.o_ila_end;
    endfunction
    function automatic logic bsy(input int w);
        return (w != 0) ? b_if.o_busy : a_if.o_busy;
    endfunction

    // Scoreboard monitors: pop and compare each valid octet.
    always @(negedge clk) begin
        if (a_if.o_valid === 1'b1) begin
            if (cap_a_n < 128) cap_a[cap_a_n] = {a_if.o_ila_end, a_if.o_is_k, a_if.o_data};
            cap_a_n++;
            if (qa.size() == 0) check("sb_a_unexpected_valid", a_if.o_valid, 0);
            else check("sb_a_octet", {a_if.o_ila_end, a_if.o_is_k, a_if.o_data}, qa.pop_front());
        end else if (a_if.o_ila_end !== 1'b0) begin
            check("sb_a_end_without_valid", a_if.o_ila_end, 0);
        end
    end

    always @(negedge clk) begin
        if (b_if.o_valid === 1'b1) begin
            if (cap_b_n < 68) cap_b[cap_b_n] = {b_if.o_ila_end, b_if.o_is_k, b_if.o_data};
            cap_b_n++;
            if (qb.size() == 0) check("sb_b_unexpected_valid", b_if.o_valid, 0);
            else check("sb_b_octet", {b_if.o_ila_end, b_if.o_is_k, b_if.o_data}, qb.pop_front());
        end else if (b_if.o_ila_end !== 1'b0) begin
            check("sb_b_end_without_valid", b_if.o_ila_end, 0);
        end
    end

    // Start a sequence (raise enable, or release reset with enable already high) and follow it.
    // stop_at >= 0 returns right after octet index stop_at has been seen.
    task automatic run_seq(input int which, input bit via_rst, input int stop_at, output int nv);
        int           f, k, exp_n, gaps, first_at;
        bit           ended, started;
        logic [111:0] cfg_keep;
        f        = (which != 0) ? 1 : 2;
        k        = (which != 0) ? 17 : 16;
        exp_n    = 4 * f * k;
        cfg_keep = (which != 0) ? b_if.i_cfg : a_if.i_cfg;
        push_seq(which, f, k, cfg_keep);
        if (which != 0) cap_b_n = 0; else cap_a_n = 0;
        @(negedge clk);
        if (via_rst)         rst_n = 1'b1;
        else if (which != 0) b_if.i_ila_en = 1'b1;
        else                 a_if.i_ila_en = 1'b1;
        @(negedge clk);
        check("valid_on_start_edge", vld(which), 0);
        check("busy_in_run", bsy(which), 1);
        // Config changes during RUN must not reach the stream.
        if (which != 0) b_if.i_cfg = ~cfg_keep; else a_if.i_cfg = ~cfg_keep;
        nv = 0; gaps = 0; ended = 0; started = 0; first_at = -1;
        for (int c = 0; c < exp_n + 8; c++) begin
            @(negedge clk);
            if (vld(which)) begin
                if (!started) first_at = c;
                started = 1;
                nv++;
            end else if (started) begin
                gaps++;
            end
            if (endp(which)) begin
                ended = 1;
                break;
            end
            if (stop_at >= 0 && nv == stop_at + 1) break;
        end
        check("first_octet_latency", first_at, 0);
        if (stop_at < 0) begin
            check("ila_end_seen", ended, 1);
            check("valid_count", nv, exp_n);
            check("valid_gaps", gaps, 0);
            check("busy_at_end", bsy(which), 0);
            @(negedge clk);
            check("valid_after_end", vld(which), 0);
            check("scoreboard_drained", (which != 0) ? qb.size() : qa.size(), 0);
        end
        if (which != 0) b_if.i_cfg = cfg_keep; else a_if.i_cfg = cfg_keep;
    endtask

    task automatic table_check(input int which);
        foreach (vt[i]) begin
            if (vt[i].dut == which) begin
                check($sformatf("vec_dut%0d_idx%0d", which, vt[i].idx),
                      (which != 0) ? cap_b[vt[i].idx] : cap_a[vt[i].idx], vt[i].val);
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        int nv;
        logic [111:0] cfg;

        // Spot-check vectors: {dut, index, {ila_end, is_k, data}}
        vt.push_back('{0,   0, {1'b0, 1'b1, 8'h1C}});
        vt.push_back('{0,   1, {1'b0, 1'b0, 8'h01}});
        vt.push_back('{0,  30, {1'b0, 1'b0, 8'h1E}});
        vt.push_back('{0,  31, {1'b0, 1'b1, 8'h7C}});
        vt.push_back('{0,  32, {1'b0, 1'b1, 8'h1C}});
        vt.push_back('{0,  33, {1'b0, 1'b1, 8'h9C}});
        vt.push_back('{0,  34, {1'b0, 1'b0, 8'hA0}});
        vt.push_back('{0,  40, {1'b0, 1'b0, 8'hA6}});
        vt.push_back('{0,  47, {1'b0, 1'b0, 8'hAD}});
        vt.push_back('{0,  48, {1'b0, 1'b0, 8'h10}});
        vt.push_back('{0,  63, {1'b0, 1'b1, 8'h7C}});
        vt.push_back('{0,  64, {1'b0, 1'b1, 8'h1C}});
        vt.push_back('{0,  65, {1'b0, 1'b0, 8'h01}});
        vt.push_back('{0,  95, {1'b0, 1'b1, 8'h7C}});
        vt.push_back('{0,  96, {1'b0, 1'b1, 8'h1C}});
        vt.push_back('{0, 126, {1'b0, 1'b0, 8'h1E}});
        vt.push_back('{0, 127, {1'b1, 1'b1, 8'h7C}});
        vt.push_back('{1,   0, {1'b0, 1'b1, 8'h1C}});
        vt.push_back('{1,   1, {1'b0, 1'b0, 8'h01}});
        vt.push_back('{1,  16, {1'b0, 1'b1, 8'h7C}});
        vt.push_back('{1,  17, {1'b0, 1'b1, 8'h1C}});
        vt.push_back('{1,  18, {1'b0, 1'b1, 8'h9C}});
        vt.push_back('{1,  19, {1'b0, 1'b0, 8'h50}});
        vt.push_back('{1,  32, {1'b0, 1'b0, 8'h5D}});
        vt.push_back('{1,  33, {1'b0, 1'b1, 8'h7C}});
        vt.push_back('{1,  34, {1'b0, 1'b1, 8'h1C}});
        vt.push_back('{1,  35, {1'b0, 1'b0, 8'h01}});
        vt.push_back('{1,  66, {1'b0, 1'b0, 8'h0F}});
        vt.push_back('{1,  67, {1'b1, 1'b1, 8'h7C}});

        rst_n = 1'b0;
        a_if.i_ila_en = 1'b0;
        b_if.i_ila_en = 1'b0;
        for (int n = 0; n < 14; n++) cfg[8 * n +: 8] = 8'hA0 + 8'(n);
        a_if.i_cfg = cfg;
        for (int n = 0; n < 14; n++) cfg[8 * n +: 8] = 8'h50 + 8'(n);
        b_if.i_cfg = cfg;

        // Reset state
        repeat (3) @(negedge clk);
        check("rst_data",    a_if.o_data, 0);
        check("rst_is_k",    a_if.o_is_k, 0);
        check("rst_valid",   a_if.o_valid, 0);
        check("rst_ila_end", a_if.o_ila_end, 0);
        check("rst_busy",    a_if.o_busy, 0);
        check("rst_b_valid", b_if.o_valid, 0);
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            check("idle_no_output", a_if.o_valid, 0);
            check("idle_not_busy", a_if.o_busy, 0);
        end

        // Full sequence with config A0..AD, then table spot checks
        run_seq(0, 1'b0, -1, nv);
        table_check(0);

        // Enable held after the end: stays DONE and silent
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            check("done_hold_valid", a_if.o_valid, 0);
            check("done_hold_busy", a_if.o_busy, 0);
        end
        a_if.i_ila_en = 1'b0;
        run_seq(0, 1'b0, -1, nv);

        // Abort after index 50, then restart from /R/
        @(negedge clk);
        a_if.i_ila_en = 1'b0;
        run_seq(0, 1'b0, 50, nv);
        #1;
        a_if.i_ila_en = 1'b0;
        check("abort_at_index", nv, 51);
        check("abort_q_left", qa.size(), 77);
        @(negedge clk);
        check("abort_valid", a_if.o_valid, 0);
        check("abort_no_end", a_if.o_ila_end, 0);
        check("abort_busy", a_if.o_busy, 0);
        qa.delete();
        run_seq(0, 1'b0, -1, nv);

        // Async reset at index 70, then full sequence after release
        @(negedge clk);
        a_if.i_ila_en = 1'b0;
        run_seq(0, 1'b0, 70, nv);
        #1;
        rst_n = 1'b0;
        #1;
        check("arst_data",    a_if.o_data, 0);
        check("arst_is_k",    a_if.o_is_k, 0);
        check("arst_valid",   a_if.o_valid, 0);
        check("arst_ila_end", a_if.o_ila_end, 0);
        check("arst_busy",    a_if.o_busy, 0);
        qa.delete();
        run_seq(0, 1'b1, -1, nv);

        // Minimum multiframe F=1, K=17
        run_seq(1, 1'b0, -1, nv);
        table_check(1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
